// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: show-ahead read port, sticky overrun flag,
// idle-data timeout and a combined level/overrun/timeout interrupt request.
module uart_rx_fifo #(
  parameter int          DEPTH_N        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  input  logic               iRX_VALID,
  input  logic [7:0]         iRX_DATA,
  input  logic               iRD_REQ,
  output logic               oRD_VALID,
  output logic [7:0]         oRD_DATA,
  output logic [DEPTH_N:0]   oCOUNT,
  output logic               oEMPTY,
  output logic               oFULL,
  output logic               oOVERRUN,
  input  logic               iOVERRUN_CLR,
  input  logic [DEPTH_N:0]   iTHRESHOLD,
  output logic               oTIMEOUT,
  output logic               oIRQ
);

  localparam int DEPTH = 1 << DEPTH_N;
  localparam logic [DEPTH_N:0] CNT_ONE      = {{DEPTH_N{1'b0}}, 1'b1};
  localparam logic [DEPTH_N:0] CNT_DEPTH_M1 = {1'b0, {DEPTH_N{1'b1}}};

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [DEPTH_N-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_N:0]   count_reg;
  logic               overrun_reg;
  logic [15:0]        tmo_reg;
  logic [7:0]         mem [DEPTH];

  logic push_acc, pop_acc, overrun_evt;

  // A push into a full FIFO is still accepted when a pop frees the head slot on the same edge.
  assign pop_acc     = iRD_REQ && (state_reg != ST_EMPTY);
  assign push_acc    = iRX_VALID && ((state_reg != ST_FULL) || iRD_REQ);
  assign overrun_evt = iRX_VALID && (state_reg == ST_FULL) && !iRD_REQ;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY:   if (push_acc) state_next = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push_acc && !pop_acc && (count_reg == CNT_DEPTH_M1))
          state_next = ST_FULL;
        else if (pop_acc && !push_acc && (count_reg == CNT_ONE))
          state_next = ST_EMPTY;
      end
      ST_FULL:    if (pop_acc && !push_acc) state_next = ST_PARTIAL;
      default:    state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_reg   <= ST_EMPTY;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
      tmo_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_acc && !pop_acc)      count_reg <= count_reg + CNT_ONE;
      else if (pop_acc && !push_acc) count_reg <= count_reg - CNT_ONE;
      // A fresh overrun beats a clear issued in the same cycle.
      if (overrun_evt)       overrun_reg <= 1'b1;
      else if (iOVERRUN_CLR) overrun_reg <= 1'b0;
      if (push_acc || pop_acc || (state_reg == ST_EMPTY)) tmo_reg <= '0;
      else if (tmo_reg < TIMEOUT_CYCLES)                  tmo_reg <= tmo_reg + 16'd1;
    end
  end

  // Storage is not reset; the read port is masked whenever the FIFO is empty.
  always_ff @(posedge iCLOCK) begin
    if (push_acc && !iRESET_SYNC) mem[wr_ptr_reg] <= iRX_DATA;
  end

  assign oRD_VALID = (state_reg != ST_EMPTY);
  assign oRD_DATA  = oRD_VALID ? mem[rd_ptr_reg] : 8'h00;
  assign oCOUNT    = count_reg;
  assign oEMPTY    = (state_reg == ST_EMPTY);
  assign oFULL     = (state_reg == ST_FULL);
  assign oOVERRUN  = overrun_reg;
  assign oTIMEOUT  = (tmo_reg == TIMEOUT_CYCLES);
  assign oIRQ      = ((iTHRESHOLD != '0) && (count_reg >= iTHRESHOLD)) || overrun_reg || oTIMEOUT;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus queues expected read bytes, a negedge
// monitor compares every accepted pop; status flags are checked inline.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       srst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rd_req;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       ovr_clr;
  logic [4:0] threshold;
  logic       timeout;
  logic       irq;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  uart_rx_fifo #(.DEPTH_N(4), .TIMEOUT_CYCLES(16'd10)) dut (
    .iCLOCK       (clk),
    .iRESET_SYNC  (srst),
    .iRX_VALID    (rx_valid),
    .iRX_DATA     (rx_data),
    .iRD_REQ      (rd_req),
    .oRD_VALID    (rd_valid),
    .oRD_DATA     (rd_data),
    .oCOUNT       (count),
    .oEMPTY       (empty),
    .oFULL        (full),
    .oOVERRUN     (overrun),
    .iOVERRUN_CLR (ovr_clr),
    .iTHRESHOLD   (threshold),
    .oTIMEOUT     (timeout),
    .oIRQ         (irq)
  );

  always #5 clk = ~clk;

  // Monitor: every pop the DUT will accept on the next edge is checked against the scoreboard.
  always @(negedge clk) begin
    if (!srst && rd_req && rd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_data: actual=%02h required=<nothing queued>", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          bad++;
          $display("FAIL pop_data: actual=%02h required=%02h", rd_data, mon_exp);
        end else begin
          $display("pop data=%02h ok", rd_data);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    rx_valid = v;
    rx_data  = d;
    rd_req   = r;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_q.push_back(d);
    cycle(1'b1, d, 1'b0);
  endtask

  initial begin
    srst = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF; rd_req = 1'b0;
    ovr_clr = 1'b0; threshold = 5'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", count, 0);    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);      chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);   chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0); chk("rst_irq", irq, 0);
    srst = 1'b0; rx_valid = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    chk("post_rst_count", count, 0);

    // Two pushes, then pops through the show-ahead head.
    push_exp(8'hA5);
    chk("t1_valid", rd_valid, 1); chk("t1_data", rd_data, 8'hA5); chk("t1_count1", count, 1);
    push_exp(8'h3C);
    chk("t1_count2", count, 2); chk("t1_head", rd_data, 8'hA5);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t1_data_after_pop", rd_data, 8'h3C); chk("t1_count_after_pop", count, 1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t1_empty", empty, 1);

    // Pop while empty is ignored; push+pop while empty takes the push only.
    cycle(1'b0, 8'h00, 1'b1);
    chk("pop_empty_count", count, 0); chk("pop_empty_flag", empty, 1);
    exp_q.push_back(8'h55);
    cycle(1'b1, 8'h55, 1'b1);
    chk("pushpop_empty_count", count, 1); chk("pushpop_empty_data", rd_data, 8'h55);
    cycle(1'b0, 8'h00, 1'b1);

    // Fill with 17 bytes; the 17th is lost and flags overrun.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      cycle(1'b1, 8'(i), 1'b0);
    end
    chk("t2_full", full, 1); chk("t2_count", count, 16); chk("t2_overrun", overrun, 1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("t2_empty", empty, 1); chk("t2_data_masked", rd_data, 0); chk("t2_count0", count, 0);
    chk("t2_overrun_sticky", overrun, 1);
    ovr_clr = 1'b1; cycle(1'b0, 8'h00, 1'b0); ovr_clr = 1'b0;
    chk("t2_overrun_clr", overrun, 0);

    // Full FIFO: simultaneous push and pop keeps count at 16 with no overrun.
    for (int i = 0; i < 16; i++) push_exp(8'h20 + 8'(i));
    chk("t3_full", full, 1);
    exp_q.push_back(8'hEE);
    cycle(1'b1, 8'hEE, 1'b1);
    chk("t3_count", count, 16); chk("t3_overrun", overrun, 0); chk("t3_still_full", full, 1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("t3_empty", empty, 1);

    // Threshold interrupt and overrun set-beats-clear.
    threshold = 5'd4;
    for (int i = 0; i < 3; i++) push_exp(8'h40 + 8'(i));
    chk("t4_irq_3", irq, 0);
    push_exp(8'h43);
    chk("t4_irq_4", irq, 1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t4_irq_after_pop", irq, 0); chk("t4_count3", count, 3);
    for (int i = 0; i < 13; i++) push_exp(8'h44 + 8'(i));
    chk("t4_full", full, 1);
    cycle(1'b1, 8'h51, 1'b0);
    chk("t4_overrun_set", overrun, 1);
    ovr_clr = 1'b1; cycle(1'b1, 8'h52, 1'b0);
    chk("t4_set_beats_clr", overrun, 1);
    cycle(1'b0, 8'h00, 1'b0); ovr_clr = 1'b0;
    chk("t4_overrun_cleared", overrun, 0); chk("t4_irq_level", irq, 1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("t4_empty", empty, 1); chk("t4_irq_empty", irq, 0);
    threshold = 5'd0;

    // Timeout asserts exactly 10 cycles after the push edge and drops after a pop.
    push_exp(8'h99);
    chk("t5_timeout_0", timeout, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 8'h00, 1'b0);
      chk($sformatf("t5_timeout_%0d", k), timeout, (k >= 10) ? 1 : 0);
    end
    chk("t5_irq_timeout", irq, 1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t5_timeout_drop", timeout, 0); chk("t5_irq_drop", irq, 0);

    // Mid-operation reset with a push in the reset cycle.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    chk("t6_count5", count, 5);
    srst = 1'b1;
    cycle(1'b1, 8'h70, 1'b0);
    srst = 1'b0;
    chk("t6_count", count, 0); chk("t6_empty", empty, 1);
    chk("t6_overrun", overrun, 0); chk("t6_irq", irq, 0); chk("t6_data", rd_data, 0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("t6_reset_push_ignored", count, 0);
    push_exp(8'h77);
    chk("t6_new_head", rd_data, 8'h77);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t6_empty_end", empty, 1);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
